uart_tx_fifo: RTL

//  Bus-mapped byte FIFO upstream of the UART transmitter. Software pushes bytes at bus speed.
//  The FIFO drains them to the UART TX byte input over a valid/ready handshake.
//  The CPU no longer polls tx-busy per byte.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/uart_tx_fifo.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register offsets shared by the UART register blocks and the
// packed field layouts of the CTRL and STAT registers.
package uart_pkg;

  // Byte offsets, decoded from addr[7:0].
  localparam logic [7:0] UART_CTRL_OFS   = 8'h00;
  localparam logic [7:0] UART_STAT_OFS   = 8'h04;
  localparam logic [7:0] UART_THRESH_OFS = 8'h08;
  localparam logic [7:0] UART_DATA_OFS   = 8'h0C;

  // CTRL: [0] drain_en, [1] irq_en, [2] flush (write-1 pulse, reads 0).
  typedef struct packed {
    logic [28:0] rsvd;
    logic        flush;
    logic        irq_en;
    logic        drain_en;
  } uart_ctrl_t;

  // STAT: [0] empty, [1] full, [2] overflow (W1C), [15:8] level.
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  level;
    logic [4:0]  rsvd_lo;
    logic        overflow;
    logic        full;
    logic        empty;
  } uart_stat_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word fall-through FIFO.
//  clk_i, rst_ni     clock, asynchronous active-low reset
//  push_i, data_i    write strobe and data; dropped when full unless popping
//  pop_i             consume head entry; ignored when empty
//  flush_i           return to empty; wins over same-cycle push/pop
//  data_o            head entry (mem[rd_ptr])
//  level_o           occupancy 0..DEPTH
//  full_o, empty_o   level == DEPTH / level == 0
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign push_ok = push_i & ~flush_i & (~full_o | pop_ok);

  // Storage; cleared on reset so the head reads 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
    end else if (flush_i) begin
      level_q <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: bus-mapped byte FIFO feeding the UART transmitter.
//  clk_i, rst_ni            clock, asynchronous active-low reset
//  req_i, we_i              bus request, 1 = write
//  addr_i, data_i           byte address ([7:0] decoded), write data
//  ready_o                  bus ack, equals req_i (never stalls)
//  data_o                   read data, 0 when no read request
//  tx_data_o, tx_valid_o    byte and valid towards the UART
//  tx_ready_i               UART accepts the byte this cycle
//  irq_o                    low-watermark interrupt, level-sensitive
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ready_o,
  output logic [31:0] data_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        irq_o
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [7:0]       ofs;
  logic             wr_en;
  logic             rd_en;
  logic             ctrl_wr;
  logic             stat_wr;
  logic             thresh_wr;
  logic             push;
  logic             pop;
  logic             flush;
  logic             ovf_set;
  logic             ovf_clr;
  uart_ctrl_t       wr_ctrl;
  uart_stat_t       wr_stat;
  uart_ctrl_t       rd_ctrl;
  uart_stat_t       rd_stat;

  logic             drain_en_q;
  logic             irq_en_q;
  logic [LVL_W-1:0] thresh_q;
  logic             ovf_q;
  logic             irq_q;

  logic [LVL_W-1:0] fifo_level;
  logic             fifo_full;
  logic             fifo_empty;

  // Address decode; only the low byte selects a register.
  assign ofs       = addr_i[7:0];
  assign wr_en     = req_i & we_i;
  assign rd_en     = req_i & ~we_i;
  assign wr_ctrl   = uart_ctrl_t'(data_i);
  assign wr_stat   = uart_stat_t'(data_i);
  assign ctrl_wr   = wr_en & (ofs == UART_CTRL_OFS);
  assign stat_wr   = wr_en & (ofs == UART_STAT_OFS);
  assign thresh_wr = wr_en & (ofs == UART_THRESH_OFS);
  assign push      = wr_en & (ofs == UART_DATA_OFS);
  assign flush     = ctrl_wr & wr_ctrl.flush;

  // Handshake: the head byte is offered only while draining is enabled.
  assign tx_valid_o = drain_en_q & ~fifo_empty;
  assign pop        = tx_valid_o & tx_ready_i;

  // A push dropped because the FIFO is full and nothing leaves this cycle.
  assign ovf_set = push & fifo_full & ~pop;
  assign ovf_clr = stat_wr & wr_stat.overflow;

  assign ready_o = req_i;
  assign irq_o   = irq_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (data_i[7:0]),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (tx_data_o),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // CTRL and THRESH registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drain_en_q <= 1'b0;
      irq_en_q   <= 1'b0;
      thresh_q   <= '0;
    end else begin
      if (ctrl_wr) begin
        drain_en_q <= wr_ctrl.drain_en;
        irq_en_q   <= wr_ctrl.irq_en;
      end
      if (thresh_wr) thresh_q <= data_i[LVL_W-1:0];
    end
  end

  // Sticky overflow; a new overflow event beats a same-cycle W1C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  // Low-watermark interrupt, registered from the current level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en_q & (fifo_level <= thresh_q);
    end
  end

  // Readback field assembly.
  always_comb begin
    rd_ctrl          = '0;
    rd_ctrl.drain_en = drain_en_q;
    rd_ctrl.irq_en   = irq_en_q;
    rd_stat          = '0;
    rd_stat.empty    = fifo_empty;
    rd_stat.full     = fifo_full;
    rd_stat.overflow = ovf_q;
    rd_stat.level    = 8'(fifo_level);
  end

  // Side-effect-free read mux.
  always_comb begin
    data_o = '0;
    if (rd_en) begin
      case (ofs)
        UART_CTRL_OFS:   data_o = rd_ctrl;
        UART_STAT_OFS:   data_o = rd_stat;
        UART_THRESH_OFS: data_o = 32'(thresh_q);
        default:         data_o = '0;
      endcase
    end
  end

  // Register fields that carry no write meaning.
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:8], wr_ctrl.rsvd, wr_stat.rsvd_hi, wr_stat.level,
                         wr_stat.rsvd_lo, wr_stat.full, wr_stat.empty};

endmodule
